// File: rtl/stopwatch_counter.sv
// stopwatch_counter: BCD MM:SS count core with run/pause and per-field adjust.
module stopwatch_counter #(
    parameter int MIN_MAX = 59,
    parameter int SEC_MAX = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       adj,
    input  logic       sel,
    input  logic       pause_pulse,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       rollover
);
    typedef enum logic {RUN, PAUSE} state_t;
    state_t state_q, state_d;
    logic [3:0] min_tens_q, min_tens_d, min_ones_q, min_ones_d;
    logic [3:0] sec_tens_q, sec_tens_d, sec_ones_q, sec_ones_d;
    logic rollover_q, rollover_d;
    logic sec_at_max, min_at_max, count, step_sec, step_min;
    always_comb begin
        sec_at_max = {3'd0, sec_tens_q} * 7'd10 + {3'd0, sec_ones_q} == 7'(SEC_MAX);
        min_at_max = {3'd0, min_tens_q} * 7'd10 + {3'd0, min_ones_q} == 7'(MIN_MAX);
        count = !adj && state_q == RUN && tick_1hz;
        step_sec = adj ? tick_2hz && sel : count;
        step_min = adj ? tick_2hz && !sel : count && sec_at_max;
        sec_ones_d = !step_sec ? sec_ones_q : (sec_at_max || sec_ones_q == 4'd9) ? 4'd0 : sec_ones_q + 4'd1;
        sec_tens_d = !step_sec ? sec_tens_q : sec_at_max ? 4'd0 : sec_ones_q == 4'd9 ? sec_tens_q + 4'd1 : sec_tens_q;
        min_ones_d = !step_min ? min_ones_q : (min_at_max || min_ones_q == 4'd9) ? 4'd0 : min_ones_q + 4'd1;
        min_tens_d = !step_min ? min_tens_q : min_at_max ? 4'd0 : min_ones_q == 4'd9 ? min_tens_q + 4'd1 : min_tens_q;
        state_d = pause_pulse ? (state_q == RUN ? PAUSE : RUN) : state_q;
        rollover_d = count && sec_at_max && min_at_max;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            min_tens_q <= 4'd0;
            min_ones_q <= 4'd0;
            sec_tens_q <= 4'd0;
            sec_ones_q <= 4'd0;
            rollover_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            min_tens_q <= min_tens_d;
            min_ones_q <= min_ones_d;
            sec_tens_q <= sec_tens_d;
            sec_ones_q <= sec_ones_d;
            rollover_q <= rollover_d;
        end
    end
    assign min_tens = min_tens_q;
    assign min_ones = min_ones_q;
    assign sec_tens = sec_tens_q;
    assign sec_ones = sec_ones_q;
    assign running  = state_q == RUN;
    assign rollover = rollover_q;
endmodule
